// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the uart_tx arbiter and its picker
package uart_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;
  localparam int STALL_W = 16;
  localparam int MAX_REQ = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wins
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);
  int best;
  int d;
  always_comb begin
    best = N;
    d = 0;
    idx = '0;
    win = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(ptr)) % N;
      if (req[i] && d < best) begin
        best = d;
        idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) win[i] = (req != '0) && (idx == IW'(i));
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular sharing of one uart_tx between requesters
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk_48,
  input  logic                 reset,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_strobe,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_evt
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t               state, state_d;
  logic [IW-1:0]        ptr, ptr_d, g, g_d, g_next, pick_idx;
  logic [NUM_REQ-1:0]   pick_win, grant_d;
  logic [7:0]           tx_data_d;
  logic                 tx_strobe_d, timeout_d, last_q, last_d, xfer;
  logic [STALL_W-1:0]   stall_cnt, stall_d;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .win(pick_win),
    .idx(pick_idx)
  );

  // grant is the one-hot of g, so it doubles as the ready mask
  assign xfer      = (state == ST_SEND) && tx_ready && req_valid[g];
  assign req_ready = xfer ? grant : '0;
  assign busy      = |grant;
  assign g_next    = (g == IW'(NUM_REQ - 1)) ? '0 : g + IW'(1);

  always_comb begin
    state_d = state;
    grant_d = grant;
    g_d = g;
    ptr_d = ptr;
    tx_data_d = tx_data;
    tx_strobe_d = 1'b0;
    timeout_d = 1'b0;
    last_d = last_q;
    stall_d = stall_cnt;
    case (state)
      ST_IDLE: if (|req_valid) begin
        state_d = ST_SEND;
        grant_d = pick_win;
        g_d = pick_idx;
        stall_d = '0;
      end
      ST_SEND: if (xfer) begin
        tx_data_d = req_data[{g, 3'b000} +: 8];
        tx_strobe_d = 1'b1;
        last_d = req_last[g];
        stall_d = '0;
        state_d = ST_GAP;
      end else if (!req_valid[g]) begin
        if (TIMEOUT != 0 && stall_cnt == STALL_LIM) begin
          timeout_d = 1'b1;
          grant_d = '0;
          ptr_d = g_next;
          state_d = ST_IDLE;
        end else begin
          stall_d = stall_cnt + STALL_W'(1);
        end
      end
      ST_GAP: begin
        state_d = last_q ? ST_IDLE : ST_SEND;
        grant_d = last_q ? '0 : grant;
        ptr_d = last_q ? g_next : ptr;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr <= '0;
      g <= '0;
      grant <= '0;
      tx_data <= '0;
      tx_strobe <= 1'b0;
      timeout_evt <= 1'b0;
      last_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      g <= g_d;
      grant <= grant_d;
      tx_data <= tx_data_d;
      tx_strobe <= tx_strobe_d;
      timeout_evt <= timeout_d;
      last_q <= last_d;
      stall_cnt <= stall_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (4 requesters, timeout 100)
module tb_uart_tx_arbiter;
  localparam int N = 4;
  logic          clk_48 = 1'b0;
  logic          reset;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_valid, req_last, req_ready, grant;
  logic [7:0]    tx_data;
  logic          tx_strobe, tx_ready, busy, timeout_evt;

  int errors = 0;
  int checks = 0;
  logic [8:0] mem [N][8];
  int head [N];
  int tail [N];
  int cyc = 0, ns = 0, wide = 0, gap_bad = 0, te_n = 0, te_c = 0;
  logic [7:0] sd [64];
  logic [3:0] sg [64];
  int sc [64];
  logic [3:0] te_g = '0;
  logic prev_s = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(100)) dut (
    .clk_48(clk_48),
    .reset(reset),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_strobe(tx_strobe),
    .tx_ready(tx_ready),
    .grant(grant),
    .busy(busy),
    .timeout_evt(timeout_evt)
  );

  always #5 clk_48 = ~clk_48;

  // strobe/timeout logger, sampled mid-cycle
  always @(negedge clk_48) begin
    cyc = cyc + 1;
    if (tx_strobe === 1'b1) begin
      if (ns < 64) begin
        sd[ns] = tx_data;
        sg[ns] = grant;
        sc[ns] = cyc;
      end
      ns = ns + 1;
      if (|req_ready) gap_bad = gap_bad + 1;
      if (prev_s) wide = wide + 1;
    end
    prev_s = (tx_strobe === 1'b1);
    if (timeout_evt === 1'b1) begin
      te_n = te_n + 1;
      te_c = cyc;
      te_g = grant;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem[r][tail[r]] = {l, d};
    tail[r] = tail[r] + 1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic v;
      v = head[i] < tail[i];
      req_valid[i] = v;
      req_data[8*i +: 8] = v ? mem[i][head[i]][7:0] : 8'h00;
      req_last[i] = v && mem[i][head[i]][8];
    end
  endtask

  task automatic step();
    logic [N-1:0] fire;
    @(negedge clk_48);
    fire = req_valid & req_ready;
    @(posedge clk_48);
    #1;
    for (int i = 0; i < N; i++) if (fire[i]) head[i] = head[i] + 1;
    drive();
  endtask

  function automatic logic all_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (!(all_empty() && grant === '0) && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(k < budget), 32'd1);
  endtask

  initial begin
    int base, te0, k;
    reset = 1'b1;
    tx_ready = 1'b1;
    clear_q();
    drive();
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_strobe", 32'(tx_strobe), 32'h0);
    chk("rst_timeout", 32'(timeout_evt), 32'h0);
    req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    drive();
    reset = 1'b0;

    // single requester "AB\r" with idle latency checks
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h0D, 1'b1);
    base = ns;
    drive();
    step();
    chk("a_grant_c1", 32'(grant), 32'h1);
    chk("a_busy_c1", 32'(busy), 32'h1);
    chk("a_ready_c1", 32'(req_ready), 32'h1);
    step();
    chk("a_strobe_c2", 32'(tx_strobe), 32'h1);
    chk("a_data_c2", 32'(tx_data), 32'h41);
    chk("a_gap_ready", 32'(req_ready), 32'h0);
    wait_idle("a_done", 50);
    chk("a_count", 32'(ns - base), 32'd3);
    chk("a_b0", 32'(sd[base]), 32'h41);
    chk("a_b1", 32'(sd[base+1]), 32'h42);
    chk("a_b2", 32'(sd[base+2]), 32'h0D);
    chk("a_g2", 32'(sg[base+2]), 32'h1);
    chk("a_space01", 32'(sc[base+1] - sc[base]), 32'd2);
    chk("a_space12", 32'(sc[base+2] - sc[base+1]), 32'd2);
    chk("a_grant_end", 32'(grant), 32'h0);
    chk("a_busy_end", 32'(busy), 32'h0);

    // simultaneous requests from 1 and 3 with ptr back at 0
    reset = 1'b1;
    clear_q();
    drive();
    step();
    reset = 1'b0;
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    push(3, 8'h31, 1'b0);
    push(3, 8'h32, 1'b1);
    base = ns;
    drive();
    wait_idle("b_done", 50);
    chk("b_count", 32'(ns - base), 32'd4);
    chk("b_d0", 32'(sd[base]), 32'h11);
    chk("b_d1", 32'(sd[base+1]), 32'h12);
    chk("b_d2", 32'(sd[base+2]), 32'h31);
    chk("b_d3", 32'(sd[base+3]), 32'h32);
    chk("b_g1", 32'(sg[base+1]), 32'h2);
    chk("b_g2", 32'(sg[base+2]), 32'h8);
    chk("b_msg_gap", 32'(sc[base+2] - sc[base+1]), 32'd3);

    // round-robin fairness, two 2-byte messages per requester
    clear_q();
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < N; r++) begin
        push(r, 8'(r*16 + m*2), 1'b0);
        push(r, 8'(r*16 + m*2 + 1), 1'b1);
      end
    base = ns;
    drive();
    wait_idle("c_done", 200);
    chk("c_count", 32'(ns - base), 32'd16);
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < N; r++)
        for (int b = 0; b < 2; b++) begin
          k = base + m*8 + r*2 + b;
          chk($sformatf("c_data_m%0d_r%0d_b%0d", m, r, b), 32'(sd[k]), 32'(r*16 + m*2 + b));
          if (b == 0) chk($sformatf("c_grant_m%0d_r%0d", m, r), 32'(sg[k]), 32'(1 << r));
        end

    // tx_ready low blocks the transfer without stalling the grant
    clear_q();
    tx_ready = 1'b0;
    push(0, 8'h55, 1'b1);
    base = ns;
    drive();
    step();
    chk("d_grant", 32'(grant), 32'h1);
    chk("d_ready_blocked", 32'(req_ready), 32'h0);
    step();
    step();
    chk("d_no_strobe", 32'(tx_strobe), 32'h0);
    tx_ready = 1'b1;
    #1;
    chk("d_ready_open", 32'(req_ready), 32'h1);
    step();
    chk("d_strobe", 32'(tx_strobe), 32'h1);
    chk("d_data", 32'(tx_data), 32'h55);
    wait_idle("d_done", 20);

    // timeout: requester 2 stalls after one non-last byte, 3 goes next
    clear_q();
    push(2, 8'h21, 1'b0);
    push(3, 8'h3A, 1'b1);
    base = ns;
    te0 = te_n;
    drive();
    wait_idle("e_done", 400);
    chk("e_count", 32'(ns - base), 32'd2);
    chk("e_d0", 32'(sd[base]), 32'h21);
    chk("e_g0", 32'(sg[base]), 32'h4);
    chk("e_pulses", 32'(te_n - te0), 32'd1);
    chk("e_te_delay", 32'(te_c - sc[base]), 32'd101);
    chk("e_te_grant", 32'(te_g), 32'h0);
    chk("e_d1", 32'(sd[base+1]), 32'h3A);
    chk("e_g1", 32'(sg[base+1]), 32'h8);
    chk("e_next_lat", 32'(sc[base+1] - te_c), 32'd2);

    // reset in the GAP of byte 2 of a 4-byte message, with ptr moved to 2 first
    clear_q();
    push(1, 8'h5A, 1'b1);
    drive();
    wait_idle("f_pre_done", 20);
    clear_q();
    push(2, 8'h61, 1'b0);
    push(2, 8'h62, 1'b0);
    push(2, 8'h63, 1'b0);
    push(2, 8'h64, 1'b1);
    drive();
    k = 0;
    while (!(tx_strobe === 1'b1 && tx_data === 8'h62) && k < 50) begin
      step();
      k++;
    end
    chk("f_gap_reached", 32'(k < 50), 32'd1);
    reset = 1'b1;
    clear_q();
    push(0, 8'h70, 1'b1);
    push(3, 8'h7F, 1'b1);
    drive();
    step();
    chk("f_rst_grant", 32'(grant), 32'h0);
    chk("f_rst_busy", 32'(busy), 32'h0);
    chk("f_rst_strobe", 32'(tx_strobe), 32'h0);
    chk("f_rst_data", 32'(tx_data), 32'h00);
    chk("f_rst_timeout", 32'(timeout_evt), 32'h0);
    chk("f_rst_ready", 32'(req_ready), 32'h0);
    reset = 1'b0;
    base = ns;
    step();
    chk("f_winner", 32'(grant), 32'h1);
    wait_idle("f_done", 30);
    chk("f_count", 32'(ns - base), 32'd2);
    chk("f_d0", 32'(sd[base]), 32'h70);
    chk("f_d1", 32'(sd[base+1]), 32'h7F);

    chk("strobe_width", 32'(wide), 32'd0);
    chk("gap_ready_low", 32'(gap_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` serializer between `NUM_REQ` byte-stream requesters, all in the `clk_48` domain. Each requester sends whole messages, delimited by `req_last`. The block grants the transmitter round-robin and holds the grant until the message ends or the requester stalls past a timeout. It drives `uart_tx`'s `data`/`data_strobe` and obeys its `ready`, including the one-cycle ready lag after a strobe.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 65535: `clk_48` cycles a granted requester may hold `req_valid` low mid-message before its grant is revoked. 0 disables the timeout.
- `clk_48` in 1: system clock, 48 MHz.
- `reset` in 1: synchronous, active-high.
- `req_data` in `8*NUM_REQ`: byte from requester i on bits `[8i+7:8i]`.
- `req_valid` in `NUM_REQ`: requester i has a byte.
- `req_last` in `NUM_REQ`: the byte from requester i is the final byte of its message.
- `req_ready` out `NUM_REQ`: byte accepted; a transfer occurs when `valid & ready` on the same edge.
- `tx_data` out 8: to `uart_tx.data`.
- `tx_strobe` out 1: to `uart_tx.data_strobe`; one-cycle pulse.
- `tx_ready` in 1: from `uart_tx.ready`.
- `grant` out `NUM_REQ`: registered one-hot owner; all zero when idle.
- `busy` out 1: high whenever `grant` is nonzero.
- `timeout_evt` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- The FSM has three states: IDLE, SEND and GAP.
- **IDLE**
  - If any `req_valid` is high, pick the first valid index scanning `ptr, ptr+1, …` modulo `NUM_REQ`.
  - Register the one-hot `grant` and go to SEND. Otherwise stay in IDLE.
- **SEND**
  - Combinationally, `req_ready[g] = tx_ready && req_valid[g]`, where g is the granted index. All other `req_ready` bits are 0, and all bits are 0 outside SEND.
  - On a transfer: `tx_data <= req_data[g]`, `tx_strobe <= 1`, store `last_q <= req_last[g]`, go to GAP.
- **GAP**: lasts exactly one cycle, the cycle in which `tx_strobe` is high.
  - Next cycle `tx_strobe <= 0`.
  - If `last_q` is set: `ptr <= (g+1) mod NUM_REQ`, `grant <= 0`, go to IDLE.
  - Otherwise return to SEND.
- **Timeout**
  - `stall_cnt`, 16 bits, counts SEND cycles with `req_valid[g]` low.
  - It clears on any transfer, and on entry to SEND from IDLE.
  - When `stall_cnt == TIMEOUT-1` and `TIMEOUT != 0`: pulse `timeout_evt`, `grant <= 0`, `ptr <= g+1`, go to IDLE. No byte is sent.
- **Reset values**: state IDLE, `ptr` 0, `grant` 0, `busy` 0, `tx_data` 0x00, `tx_strobe` 0, `timeout_evt` 0, `stall_cnt` 0, `req_ready` 0.
- **Reset mid-message**: the message is abandoned immediately. A strobe already issued is not retracted, because `uart_tx` has already latched the byte.
- **Simultaneous requests**: exactly one winner per IDLE decision. A requester raising `req_valid` during another's message waits until that message completes or times out.
- **`req_last` on a single-byte message**: sent normally; the grant is released after GAP.

## Timing
- Idle request latency:
  - `req_valid` rises in cycle 0 (IDLE): `grant` is valid in cycle 1.
  - `req_ready` can be high in cycle 1, if `tx_ready` is high.
  - `tx_strobe` is high in cycle 2.
- Strobe spacing:
  - GAP guarantees no transfer in the cycle where `tx_strobe` is high.
  - `uart_tx.ready` falls in the cycle after the strobe. SEND therefore never sees stale `tx_ready` from the previous byte.
- Message throughput is limited by `uart_tx`, not the arbiter. Per-byte arbiter overhead is 2 cycles, and per-message overhead is 1 IDLE cycle.
- Inter-message gap: the last byte's strobe is in cycle k. The next message's grant appears at k+2 at the earliest.

## Structure
- Package `uart_arb_pkg`:
  - FSM state enum: `ST_IDLE`, `ST_SEND`, `ST_GAP`.
  - `STALL_W = 16`.
  - `MAX_REQ = 8`.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: `NUM_REQ` request vector and `ptr`.
  - Outputs: one-hot winner and its index.
  - It is reusable for future shared resources (SPI flash, LEDs).
- `uart_tx_arbiter` holds the FSM, grant/`ptr`/data registers and the stall counter.

## Test plan
- **Single requester**: requester 0 sends "AB\r" (`req_last` on `\r`) with `tx_ready` modelled by a `uart_tx` instance at 1 MHz baud_x1. Expect serial output `0x41 0x42 0x0D`, three strobes each one cycle wide, and `grant` 0b0001 then 0.
- **Simultaneous requests**: requesters 1 and 3 both raise valid in the same IDLE cycle with `ptr` = 0. Expect requester 1's full message first, then requester 3's, with no interleaved bytes.
- **Round-robin fairness**: all four requesters continuously send 2-byte messages. Expect grant order 0,1,2,3,0, …
- **Timeout**: with `TIMEOUT` = 100, requester 2 sends one non-last byte, then drops valid. Expect `timeout_evt` exactly 100 cycles after the SEND re-entry, `grant` 0, and requester 3 served next.
- **Strobe guard**: hold `tx_ready` high constantly (stuck model). Expect strobes no closer than 2 cycles apart and `req_ready` low during every GAP cycle.
- **Reset mid-message**: assert `reset` during the GAP of byte 2 of a 4-byte message. Expect all outputs at reset values the next cycle and `ptr` 0; requester 0 wins the following arbitration.
